// File: rtl/uart_pkg.sv
// Shared UART types and constants for the Sensor UART Interface transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // Integer-truncated clocks per bit; a non-integer ratio rounds the bit period down.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/fpga_uart_tx_if.sv
// Byte handshake and line/status bundle of the UART transmitter.
interface fpga_uart_tx_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic                      uart_tx;
    logic                      tx_busy;
    logic [COUNT_W-1:0]        fifo_count;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, uart_tx, tx_busy, fifo_count
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, uart_tx, tx_busy, fifo_count
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO; pointers wrap naturally because DEPTH is a power of two.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rd_data = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fpga_uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialised LSB first, frames sent back-to-back.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte (pops it on entry to START)
//   START | start bit (0) for one bit period
//   DATA  | shift[0] on the line, eight bit periods, shifting right each period
//   STOP  | stop bit (1); last cycle pops the next byte if one is queued
module fpga_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fpga_uart_tx_if.slave  tx_if
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_t               state;
    uart_state_t               state_nxt;
    logic [BAUD_W-1:0]         baud_cnt;
    logic                      baud_tc;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      line_nxt;
    logic                      uart_tx_q;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rd;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_if.tx_valid),
        .wr_data (tx_if.tx_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (tx_if.fifo_count)
    );

    assign baud_tc        = (baud_cnt == '0);
    assign tx_if.tx_ready = !fifo_full;
    assign tx_if.tx_busy  = (state != IDLE) || !fifo_empty;
    assign tx_if.uart_tx  = uart_tx_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        line_nxt  = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                line_nxt = 1'b0;
                if (baud_tc) state_nxt = DATA;
            end
            DATA: begin
                line_nxt = shift[0];
                if (baud_tc && (bit_idx == LAST_BIT)) state_nxt = STOP;
            end
            STOP: begin
                if (baud_tc) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line is registered from the current state, so it trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt  <= BAUD_LOAD;
            bit_idx   <= '0;
            shift     <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            uart_tx_q <= line_nxt;

            if (fifo_pop)                    shift <= fifo_rd;
            else if (state == DATA && baud_tc) shift <= shift >> 1;

            if (state == IDLE || baud_tc) baud_cnt <= BAUD_LOAD;
            else                          baud_cnt <= baud_cnt - 1'b1;

            if (state == START)                bit_idx <= '0;
            else if (state == DATA && baud_tc) bit_idx <= bit_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_fpga_uart_tx.sv
// Scoreboard bench for fpga_uart_tx: driver queues accepted bytes, line monitor decodes frames.
module tb_fpga_uart_tx;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 77;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_FREQ / BAUD;   // 12 clocks per bit
    localparam int FRAME    = 10 * CPB;

    typedef struct {
        logic [7:0] data;
        int         acc;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    item_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    inv_bad  = 0;
    int    frames   = 0;
    int    n_pushed = 0;

    fpga_uart_tx_if #(.FIFO_DEPTH(DEPTH)) tx_if ();

    fpga_uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (tx_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // tx_ready must mirror "not full", and the queue can never exceed its depth.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_if.fifo_count > DEPTH || tx_if.tx_ready != (tx_if.fifo_count != DEPTH))
                inv_bad++;
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int guard = 0;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = b;
        while (!tx_if.tx_ready && guard < 50 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        if (!tx_if.tx_ready) begin
            check("push_timeout", 0, 1);
            tx_if.tx_valid = 1'b0;
        end else begin
            @(negedge clk);
            sb.push_back('{data: b, acc: cyc});
            n_pushed++;
        end
    endtask

    task automatic idle(input int n);
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        int guard = 0;
        tx_if.tx_valid = 1'b0;
        while ((sb.size() != 0 || tx_if.tx_busy) && guard < 30 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", (sb.size() == 0 && !tx_if.tx_busy) ? 1 : 0, 1);
    endtask

    // Line monitor: a frame starts at a 1->0 transition and its expected byte is the scoreboard head.
    initial begin : monitor
        logic       prev;
        int         prev_end;
        int         exp_start;
        item_t      it;
        logic [9:0] fr;
        logic [7:0] dec;
        int         bad;
        bit         aborted;
        prev     = 1'b1;
        prev_end = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev     = 1'b1;
                prev_end = 0;
            end else if (prev && !tx_if.uart_tx) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    prev = tx_if.uart_tx;
                end else begin
                    it        = sb.pop_front();
                    exp_start = (it.acc + 2 > prev_end) ? it.acc + 2 : prev_end;
                    check("start_time", cyc, exp_start);
                    fr      = {1'b1, it.data, 1'b0};
                    bad     = 0;
                    dec     = 8'h00;
                    aborted = 1'b0;
                    for (int t = 0; t < FRAME; t++) begin
                        if (t > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx_if.uart_tx !== fr[t / CPB]) bad++;
                        if ((t % CPB) == CPB / 2 && t >= CPB && t < 9 * CPB)
                            dec[t / CPB - 1] = tx_if.uart_tx;
                        if (t == FRAME - 2) check("busy_in_frame", int'(tx_if.tx_busy), 1);
                    end
                    if (aborted) begin
                        prev     = 1'b1;
                        prev_end = 0;
                    end else begin
                        check("frame_shape", bad, 0);
                        check("frame_data", int'(dec), int'(it.data));
                        #1;
                        if (sb.size() == 0) check("busy_end", int'(tx_if.tx_busy), 0);
                        prev_end = cyc + 1;
                        prev     = tx_if.uart_tx;
                        frames++;
                    end
                end
            end else begin
                prev = tx_if.uart_tx;
            end
        end
    end

    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int guard;
        int gap;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_line",  int'(tx_if.uart_tx),    1);
        check("rst_ready", int'(tx_if.tx_ready),   1);
        check("rst_busy",  int'(tx_if.tx_busy),    0);
        check("rst_count", int'(tx_if.fifo_count), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: latency and idle behaviour
        push_byte(8'h01);
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'hFF;
        check("acc_count", int'(tx_if.fifo_count), 1);
        check("acc_busy",  int'(tx_if.tx_busy),    1);
        check("acc_line",  int'(tx_if.uart_tx),    1);
        @(negedge clk);
        check("pop_count", int'(tx_if.fifo_count), 0);
        check("pop_line",  int'(tx_if.uart_tx),    1);
        @(negedge clk);
        check("start_line", int'(tx_if.uart_tx), 0);
        wait_drain();
        idle(5);

        // Back-to-back frames
        push_byte(8'h02);
        push_byte(8'h04);
        wait_drain();
        idle(5);

        // FIFO full with tx_valid held
        for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
        check("full_count", int'(tx_if.fifo_count), DEPTH);
        check("full_ready", int'(tx_if.tx_ready),   0);
        push_byte(8'h15);
        wait_drain();
        idle(5);

        // Reset during data bit 3 of 0xA5, with a second byte still queued
        push_byte(8'hA5);
        push_byte(8'h77);
        tx_if.tx_valid = 1'b0;
        guard = 0;
        while (tx_if.uart_tx && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        check("rst_frame_seen", int'(tx_if.uart_tx), 0);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_line",  int'(tx_if.uart_tx),    1);
        check("midrst_count", int'(tx_if.fifo_count), 0);
        check("midrst_busy",  int'(tx_if.tx_busy),    0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_byte(8'h5A);
        wait_drain();
        idle(3);

        // Random bytes with random gaps, mixing idle starts and back-to-back runs
        for (int i = 0; i < 14; i++) begin
            push_byte(8'($urandom));
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2 * FRAME);
            if (gap > 0) idle(gap);
        end
        wait_drain();
        idle(10);

        check("ready_invariant", inv_bad, 0);
        check("frame_total", frames, n_pushed - 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
